sa_result_collector: RTL and testbench

Downstream stage of the 4x4 systolic array. Captures the skewed partial sums leaving the bottom row of PEs (column j valid one cycle after column j-1), de-skews them into complete result rows, buffers them in a small FIFO and presents them to the result writer over a valid/ready handshake. It also raises back-pressure toward the array controller and flags overflow and protocol errors.

---
 rtl/sa_pkg.sv | 18 +
 rtl/sa_result_collector_if.sv | 33 +++
 rtl/sa_row_fifo.sv | 83 ++++++++
 rtl/sa_result_collector.sv | 109 ++++++++++
 tb/tb_sa_result_collector.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/sa_pkg.sv
// Shared systolic-array package: array geometry, row-index width and the
// result-row types used by the collector and its FIFO.
package sa_pkg;

   localparam int unsigned N       = 4;   // columns per row, rows per tile
   localparam int unsigned W       = 16;  // partial-sum width
   localparam int unsigned RowIdxW = (N > 1) ? $clog2(N) : 1;

   typedef logic [N*W-1:0]     row_t;
   typedef logic [RowIdxW-1:0] row_idx_t;

   // One buffered result row: data plus its row index within the tile.
   typedef struct packed {
      row_idx_t idx;
      row_t     data;
   } row_entry_t;

endpackage

// File: rtl/sa_result_collector_if.sv
// Result-row handshake between the collector (master) and the result writer
// (slave).
//   out_valid   : row available
//   out_ready   : consumer accepts row
//   out_data    : de-skewed row, column j at [j*W +: W]
//   out_row_idx : row index within tile
//   out_last    : out_row_idx == N-1
interface sa_result_collector_if;
   import sa_pkg::*;

   logic     out_valid;
   logic     out_ready;
   row_t     out_data;
   row_idx_t out_row_idx;
   logic     out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_row_idx,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_row_idx,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/sa_row_fifo.sv
// Synchronous result-row FIFO with registered storage and a registered full
// flag. The head entry is read straight from the storage registers, so there
// is no fall-through: a row pushed into an empty FIFO is visible next cycle.
//   Clock, rst_n : clock, asynchronous active-low reset
//   clear        : synchronous flush of pointers and count
//   push/push_data : write request (dropped when full and not popping)
//   pop          : read request, ignored when empty
//   pop_data     : head entry
//   empty, full  : occupancy flags
module sa_row_fifo
   import sa_pkg::*;
#(
   parameter int unsigned DEPTH = 4  // power of 2, at least 2
) (
   input  logic       Clock,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       push,
   input  row_entry_t push_data,
   input  logic       pop,
   output row_entry_t pop_data,
   output logic       empty,
   output logic       full
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   row_entry_t      mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            full_q, full_d;
   logic            do_push, do_pop;

   always_comb begin
      do_pop   = pop && (cnt_q != '0) && !clear;
      // A full FIFO still accepts a push when the head leaves this cycle.
      do_push  = push && (!full_q || do_pop) && !clear;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of 2.
         if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         if (do_push && !do_pop)      cnt_d = cnt_q + CntW'(1);
         else if (do_pop && !do_push) cnt_d = cnt_q - CntW'(1);
      end
      full_d = (cnt_d == CntW'(DEPTH));
   end

   always_ff @(posedge Clock or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         full_q   <= full_d;
      end
   end

   always_ff @(posedge Clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign empty    = (cnt_q == '0);
   assign full     = full_q;

endmodule

// File: rtl/sa_result_collector.sv
// Collects the skewed partial sums leaving the bottom PE row, assembles them
// into complete result rows, buffers the rows and hands them to the result
// writer. N and W come from sa_pkg so they stay in step with the PE array.
//   Clock, rst_n : clock, asynchronous active-low reset
//   data_clear   : synchronous flush of assembly mask, FIFO, row counter, flags
//   ps_bottom    : bottom-PE partial sums, column j at [j*W +: W]
//   col_strobe   : column j sum valid this cycle
//   result       : result-row handshake (master side)
//   fifo_full    : FIFO holds DEPTH rows; controller must stall the array
//   err_overflow : sticky, a completed row was dropped on a full FIFO
//   err_dup      : sticky, a column was strobed twice for the pending row
module sa_result_collector
   import sa_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                  Clock,
   input  logic                  rst_n,
   input  logic                  data_clear,
   input  row_t                  ps_bottom,
   input  logic [N-1:0]          col_strobe,
   sa_result_collector_if.master result,
   output logic                  fifo_full,
   output logic                  err_overflow,
   output logic                  err_dup
);

   row_t       asm_data_q, asm_data_d;
   logic [N-1:0] asm_mask_q, asm_mask_d;
   row_idx_t   row_cnt_q, row_cnt_d;
   logic       err_ovf_q, err_ovf_d;
   logic       err_dup_q, err_dup_d;

   logic [N-1:0] strobe_new, next_mask;
   logic       row_done, push_req, overflow, pop, fifo_empty;
   row_entry_t push_entry, head;

   always_comb begin
      strobe_new = col_strobe & ~asm_mask_q;
      next_mask  = asm_mask_q | col_strobe;
      row_done   = &next_mask;
      pop        = result.out_valid && result.out_ready;
      push_req   = row_done && !data_clear;
      overflow   = push_req && fifo_full && !pop;

      // A duplicate strobe keeps the value already captured for that column.
      asm_data_d = asm_data_q;
      for (int j = 0; j < N; j++) begin
         if (strobe_new[j]) asm_data_d[j*W +: W] = ps_bottom[j*W +: W];
      end
      push_entry.data = asm_data_d;
      push_entry.idx  = row_cnt_q;

      asm_mask_d = row_done ? '0 : next_mask;
      row_cnt_d  = row_cnt_q;
      if (push_req && !overflow) begin
         row_cnt_d = (row_cnt_q == row_idx_t'(N - 1)) ? '0 : row_cnt_q + row_idx_t'(1);
      end
      err_ovf_d = err_ovf_q | overflow;
      err_dup_d = err_dup_q | (|(col_strobe & asm_mask_q));

      // Clear wins over strobes; the assembled data itself is left in place.
      if (data_clear) begin
         asm_data_d = asm_data_q;
         asm_mask_d = '0;
         row_cnt_d  = '0;
         err_ovf_d  = 1'b0;
         err_dup_d  = 1'b0;
      end
   end

   always_ff @(posedge Clock or negedge rst_n) begin
      if (!rst_n) begin
         asm_data_q <= '0;
         asm_mask_q <= '0;
         row_cnt_q  <= '0;
         err_ovf_q  <= 1'b0;
         err_dup_q  <= 1'b0;
      end else begin
         asm_data_q <= asm_data_d;
         asm_mask_q <= asm_mask_d;
         row_cnt_q  <= row_cnt_d;
         err_ovf_q  <= err_ovf_d;
         err_dup_q  <= err_dup_d;
      end
   end

   sa_row_fifo #(
      .DEPTH (DEPTH)
   ) u_row_fifo (
      .Clock     (Clock),
      .rst_n     (rst_n),
      .clear     (data_clear),
      .push      (push_req),
      .push_data (push_entry),
      .pop       (pop),
      .pop_data  (head),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign result.out_valid   = !fifo_empty;
   assign result.out_data    = head.data;
   assign result.out_row_idx = head.idx;
   assign result.out_last    = (head.idx == row_idx_t'(N - 1));
   assign err_overflow       = err_ovf_q;
   assign err_dup            = err_dup_q;

endmodule

// File: tb/tb_sa_result_collector.sv
// Bench for sa_result_collector: directed scenarios plus randomized strobes,
// all checked each cycle against a queue-based row model.
module tb_sa_result_collector;
   import sa_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic         Clock;
   logic         rst_n;
   logic         data_clear;
   row_t         ps_bottom;
   logic [N-1:0] col_strobe;
   logic         fifo_full;
   logic         err_overflow;
   logic         err_dup;

   sa_result_collector_if res_if ();

   sa_result_collector #(
      .DEPTH (DEPTH)
   ) dut (
      .Clock        (Clock),
      .rst_n        (rst_n),
      .data_clear   (data_clear),
      .ps_bottom    (ps_bottom),
      .col_strobe   (col_strobe),
      .result       (res_if),
      .fifo_full    (fifo_full),
      .err_overflow (err_overflow),
      .err_dup      (err_dup)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   // Reference model: pending column values, a set of captured columns and a
   // queue of completed rows waiting for the consumer.
   typedef struct {
      logic [63:0] d;
      int unsigned idx;
   } mrow_t;

   logic [W-1:0] m_val [N];
   logic [N-1:0] m_have;
   mrow_t        m_q[$];
   int unsigned  m_wrow;
   bit           m_ovf, m_dup;

   function automatic logic [63:0] row4(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
      logic [63:0] r;
      r = {d[15:0], c[15:0], b[15:0], a[15:0]};
      return r;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_have = '0;
      m_wrow = 0;
      m_ovf  = 1'b0;
      m_dup  = 1'b0;
   endtask

   task automatic model_step(input logic [N-1:0] s, input logic [63:0] ps, input bit rdy,
                             input bit clr);
      int unsigned sz;
      bit          popped;
      mrow_t       r;
      if (clr) begin
         model_reset();
         return;
      end
      sz     = m_q.size();
      popped = (sz != 0) && rdy;
      for (int j = 0; j < N; j++) begin
         if (s[j]) begin
            if (m_have[j]) m_dup = 1'b1;
            else begin
               m_val[j]  = ps[j*W +: W];
               m_have[j] = 1'b1;
            end
         end
      end
      if (popped) void'(m_q.pop_front());
      if (&m_have) begin
         m_have = '0;
         if (sz == DEPTH && !popped) m_ovf = 1'b1;
         else begin
            for (int j = 0; j < N; j++) r.d[j*W +: W] = m_val[j];
            r.idx = m_wrow;
            m_q.push_back(r);
            m_wrow = (m_wrow + 1) % N;
         end
      end
   endtask

   task automatic compare_all();
      bit ev;
      ev = (m_q.size() != 0);
      check("out_valid", 64'(res_if.out_valid), 64'(ev));
      if (ev) begin
         check("out_data", 64'(res_if.out_data), m_q[0].d);
         check("out_row_idx", 64'(res_if.out_row_idx), 64'(m_q[0].idx));
         check("out_last", 64'(res_if.out_last), 64'(m_q[0].idx == N - 1));
      end
      check("fifo_full", 64'(fifo_full), 64'(m_q.size() == DEPTH));
      check("err_overflow", 64'(err_overflow), 64'(m_ovf));
      check("err_dup", 64'(err_dup), 64'(m_dup));
   endtask

   // Drive one cycle of inputs (called just after a falling edge), advance the
   // model on the rising edge and compare on the next falling edge.
   task automatic tick(input logic [N-1:0] s, input logic [63:0] ps, input bit rdy,
                       input bit clr);
      col_strobe       = s;
      ps_bottom        = ps;
      res_if.out_ready = rdy;
      data_clear       = clr;
      @(posedge Clock);
      model_step(s, ps, rdy, clr);
      @(negedge Clock);
      compare_all();
   endtask

   task automatic send_row(input logic [63:0] row, input bit rdy, input bit rdy_last);
      for (int j = 0; j < N; j++) begin
         tick(N'(1 << j), row, (j == N - 1) ? rdy_last : rdy, 1'b0);
      end
   endtask

   task automatic idle(input int unsigned n, input bit rdy);
      for (int i = 0; i < n; i++) tick('0, '0, rdy, 1'b0);
   endtask

   initial begin
      logic [N-1:0] s;
      bit           rdy, clr;

      rst_n            = 1'b0;
      data_clear       = 1'b0;
      ps_bottom        = '0;
      col_strobe       = '0;
      res_if.out_ready = 1'b0;
      model_reset();
      for (int j = 0; j < N; j++) m_val[j] = '0;
      repeat (2) @(negedge Clock);
      check("rst_out_valid", 64'(res_if.out_valid), 64'd0);
      check("rst_out_data", 64'(res_if.out_data), 64'd0);
      check("rst_out_row_idx", 64'(res_if.out_row_idx), 64'd0);
      check("rst_out_last", 64'(res_if.out_last), 64'd0);
      check("rst_fifo_full", 64'(fifo_full), 64'd0);
      check("rst_err_overflow", 64'(err_overflow), 64'd0);
      check("rst_err_dup", 64'(err_dup), 64'd0);
      rst_n = 1'b1;

      // Skewed row 10,20,30,40: visible the cycle after the last strobe.
      send_row(row4(10, 20, 30, 40), 1'b0, 1'b0);
      check("skew_valid", 64'(res_if.out_valid), 64'd1);
      check("skew_data", 64'(res_if.out_data), row4(10, 20, 30, 40));
      check("skew_idx", 64'(res_if.out_row_idx), 64'd0);
      check("skew_last", 64'(res_if.out_last), 64'd0);
      idle(2, 1'b1);

      // Full tile with the consumer always ready.
      for (int r = 0; r < N; r++) send_row(row4(r + 1, r + 11, r + 21, r + 31), 1'b1, 1'b1);
      idle(2, 1'b1);
      check("tile_no_ovf", 64'(err_overflow), 64'd0);
      check("tile_no_dup", 64'(err_dup), 64'd0);

      // Back-pressure: fifth row is dropped, then exactly four rows drain.
      tick('0, '0, 1'b0, 1'b1);
      for (int r = 0; r < 5; r++) send_row(row4(100 + r, 200 + r, 300 + r, 400 + r), 1'b0, 1'b0);
      check("bp_full", 64'(fifo_full), 64'd1);
      check("bp_overflow", 64'(err_overflow), 64'd1);
      idle(DEPTH, 1'b1);
      check("bp_drained", 64'(res_if.out_valid), 64'd0);

      // Push and pop together while full.
      tick('0, '0, 1'b0, 1'b1);
      for (int r = 0; r < DEPTH; r++) send_row(row4(r, r + 50, r + 60, r + 70), 1'b0, 1'b0);
      send_row(row4(9, 8, 7, 6), 1'b0, 1'b1);
      check("pp_full", 64'(fifo_full), 64'd1);
      check("pp_no_ovf", 64'(err_overflow), 64'd0);
      idle(DEPTH + 1, 1'b1);

      // Duplicate strobe on column 2: first value is kept.
      tick('0, '0, 1'b0, 1'b1);
      tick(4'b0100, row4(0, 0, 7, 0), 1'b0, 1'b0);
      tick(4'b0100, row4(0, 0, 9, 0), 1'b0, 1'b0);
      tick(4'b0001, row4(1, 0, 0, 0), 1'b0, 1'b0);
      tick(4'b0010, row4(0, 2, 0, 0), 1'b0, 1'b0);
      tick(4'b1000, row4(0, 0, 0, 4), 1'b0, 1'b0);
      check("dup_flag", 64'(err_dup), 64'd1);
      check("dup_col2", 64'(res_if.out_data[47:32]), 64'd7);
      idle(2, 1'b1);

      // data_clear with two rows buffered and a half-assembled row.
      tick('0, '0, 1'b0, 1'b1);
      send_row(row4(1, 2, 3, 4), 1'b0, 1'b0);
      send_row(row4(5, 6, 7, 8), 1'b0, 1'b0);
      tick(4'b0001, row4(11, 0, 0, 0), 1'b0, 1'b0);
      tick(4'b0010, row4(0, 12, 0, 0), 1'b0, 1'b0);
      tick('0, '0, 1'b0, 1'b1);
      check("clr_valid", 64'(res_if.out_valid), 64'd0);
      check("clr_full", 64'(fifo_full), 64'd0);
      send_row(row4(21, 22, 23, 24), 1'b0, 1'b0);
      check("clr_new_idx", 64'(res_if.out_row_idx), 64'd0);
      check("clr_new_data", 64'(res_if.out_data), row4(21, 22, 23, 24));
      idle(2, 1'b1);

      // Randomized strobes, data, back-pressure and occasional clears.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(4, 0) != 0) s = N'($urandom) & ~m_have;
         else s = N'($urandom);
         rdy = (i < 400) ? ($urandom_range(3, 0) == 0) : ($urandom_range(2, 0) != 0);
         clr = ($urandom_range(79, 0) == 0);
         tick(s, {$urandom, $urandom}, rdy, clr);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
